// File: rtl/diferenca_acum_if.sv
`default_nettype none
// ============================================================================
// Module      : diferenca_acum_if
// Description : Operand/result bundle for the diferenca_acum absolute-difference
//               unit. The operand side uses a valid/ready handshake and so does
//               the result side.
//               master : operand source and result consumer
//               slave  : the diferenca_acum block
//   in_valid/in_ready   operand pair handshake (A, B, acum, limpar)
//   out_valid/out_ready result handshake (S, sinal, soma, soma_valid, ovf)
// Revision    : 1.0 - initial release
// ============================================================================
interface diferenca_acum_if #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 acum;
    logic                 limpar;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     S;
    logic                 sinal;
    logic [ACC_WIDTH-1:0] soma;
    logic                 soma_valid;
    logic                 ovf;

    modport master (
        output in_valid, A, B, acum, limpar, out_ready,
        input  in_ready, out_valid, S, sinal, soma, soma_valid, ovf
    );

    modport slave (
        input  in_valid, A, B, acum, limpar, out_ready,
        output in_ready, out_valid, S, sinal, soma, soma_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/diferenca_acum.sv
`default_nettype none
// ============================================================================
// Module      : diferenca_acum
// Description : Registered |A-B| unit with sign flag and optional
//               sum-of-absolute-differences accumulation over blocks of
//               N_SAMPLES pairs, behind a one-deep valid/ready output buffer.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - diferenca_acum_if.slave (operand and result handshakes)
// Build macro : DIFERENCA_ACUM_SAT_EN - accumulator saturates instead of
//               wrapping on overflow (ovf behaves the same in both builds)
// Revision    : 1.0 - initial release
// ============================================================================
module diferenca_acum #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8,
    parameter int N_SAMPLES = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    diferenca_acum_if.slave    bus
);
    localparam int                 c_cnt_w = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N_SAMPLES - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        CHEIO  = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_s;
    logic                 r_sinal;
    logic [ACC_WIDTH-1:0] r_soma;
    logic                 r_soma_valid;
    logic                 r_ovf_out;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_neg;
    logic [ACC_WIDTH-1:0] w_base_acc;
    logic [c_cnt_w-1:0]   w_base_cnt;
    logic                 w_base_ovf;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_new_acc;
    logic                 w_new_ovf;
    logic                 w_last;

    assign w_in_ready = (r_state == OCIOSO) || bus.out_ready;
    assign w_xfer     = bus.in_valid && w_in_ready;

    always_comb begin
        w_neg  = (bus.A < bus.B);
        w_diff = w_neg ? (bus.B - bus.A) : (bus.A - bus.B);

        // limpar alongside a transfer makes that pair the first of a new block.
        w_base_acc = bus.limpar ? '0   : r_acc;
        w_base_cnt = bus.limpar ? '0   : r_cnt;
        w_base_ovf = bus.limpar ? 1'b0 : r_ovf;

        // One extra bit keeps the carry-out, which is the overflow indication.
        w_sum = {1'b0, w_base_acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, w_diff};
`ifdef DIFERENCA_ACUM_SAT_EN
        // Once saturated the accumulator sits at full scale; adding a
        // non-negative value keeps it there for the rest of the block.
        w_new_acc = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
        w_new_acc = w_sum[ACC_WIDTH-1:0];
`endif
        w_new_ovf = w_base_ovf | w_sum[ACC_WIDTH];
        w_last    = (w_base_cnt == c_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= OCIOSO;
            r_s          <= '0;
            r_sinal      <= 1'b0;
            r_soma       <= '0;
            r_soma_valid <= 1'b0;
            r_ovf_out    <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
        end else if (w_xfer) begin
            r_state <= CHEIO;
            r_s     <= w_diff;
            r_sinal <= w_neg;
            if (bus.acum) begin
                // Outputs show the block's value including this pair; the
                // internal state restarts when the block completes.
                r_soma       <= w_new_acc;
                r_ovf_out    <= w_new_ovf;
                r_soma_valid <= w_last;
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= w_new_acc;
                    r_cnt <= w_base_cnt + c_one;
                    r_ovf <= w_new_ovf;
                end
            end else begin
                r_soma       <= w_base_acc;
                r_ovf_out    <= w_base_ovf;
                r_soma_valid <= 1'b0;
                r_acc        <= w_base_acc;
                r_cnt        <= w_base_cnt;
                r_ovf        <= w_base_ovf;
            end
        end else begin
            // Result consumed with nothing new: drop out_valid, keep the data.
            if (r_state == CHEIO && bus.out_ready) begin
                r_state <= OCIOSO;
            end
            // A clear without a transfer leaves any pending result untouched.
            if (bus.limpar) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == CHEIO);
    assign bus.S          = r_s;
    assign bus.sinal      = r_sinal;
    assign bus.soma       = r_soma;
    assign bus.soma_valid = r_soma_valid;
    assign bus.ovf        = r_ovf_out;
endmodule
`default_nettype wire

// File: tb/tb_diferenca_acum.sv
`default_nettype none
// ============================================================================
// Module      : tb_diferenca_acum
// Description : Self-checking bench for diferenca_acum. Main instance uses the
//               default parameters; a second instance with ACC_WIDTH=5 covers
//               accumulator overflow (wrap or saturate, per
//               DIFERENCA_ACUM_SAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diferenca_acum;
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    diferenca_acum_if #(.WIDTH(4), .ACC_WIDTH(8)) bus ();
    diferenca_acum_if #(.WIDTH(4), .ACC_WIDTH(5)) bus5 ();

    diferenca_acum #(.WIDTH(4), .ACC_WIDTH(8), .N_SAMPLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    diferenca_acum #(.WIDTH(4), .ACC_WIDTH(5), .N_SAMPLES(4)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5.slave)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       acum;
        logic       limpar;
        logic [3:0] s;
        logic       sinal;
        logic [7:0] soma;
        logic       sv;
        logic       ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];
    vec_t tbl[15];

    function automatic vec_t mk(input int a, input int b, input int ac, input int lp,
                                input int s, input int sg, input int sm, input int sv,
                                input int ov);
        vec_t r;
        r.a      = 4'(a);
        r.b      = 4'(b);
        r.acum   = 1'(ac);
        r.limpar = 1'(lp);
        r.s      = 4'(s);
        r.sinal  = 1'(sg);
        r.soma   = 8'(sm);
        r.sv     = 1'(sv);
        r.ovf    = 1'(ov);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Called just after an active edge. Drives one pair, pushes its expected
    // result when the handshake completes, and pops/compares after the edge.
    task automatic apply(input vec_t v, input string tag);
        logic xfer;
        vec_t e;
        bus.in_valid = 1'b1;
        bus.A        = v.a;
        bus.B        = v.b;
        bus.acum     = v.acum;
        bus.limpar   = v.limpar;
        #1;
        xfer = bus.in_valid && bus.in_ready;
        chk({tag, "_accept"}, 32'(xfer), 32'd1);
        if (xfer) exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (xfer && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd1);
            chk({tag, "_S"},          32'(bus.S),          32'(e.s));
            chk({tag, "_sinal"},      32'(bus.sinal),      32'(e.sinal));
            chk({tag, "_soma"},       32'(bus.soma),       32'(e.soma));
            chk({tag, "_soma_valid"}, 32'(bus.soma_valid), 32'(e.sv));
            chk({tag, "_ovf"},        32'(bus.ovf),        32'(e.ovf));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_soma5[5];
        int exp_ovf5[5];
        int exp_sv5[5];

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.acum      = 1'b0;
        bus.limpar    = 1'b0;
        bus.out_ready = 1'b0;
        bus5.in_valid = 1'b0;
        bus5.A        = '0;
        bus5.B        = '0;
        bus5.acum     = 1'b0;
        bus5.limpar   = 1'b0;
        bus5.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_S",          32'(bus.S),          32'd0);
        chk("rst_soma",       32'(bus.soma),       32'd0);
        chk("rst_soma_valid", 32'(bus.soma_valid), 32'd0);
        chk("rst_ovf",        32'(bus.ovf),        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;

        // Basic differences, one accumulation block, limpar with transfers
        tbl = '{
            mk(3, 9, 0, 0,  6, 1,  0, 0, 0),
            mk(9, 3, 0, 0,  6, 0,  0, 0, 0),
            mk(7, 7, 0, 0,  0, 0,  0, 0, 0),
            mk(0, 15, 1, 0, 15, 1, 15, 0, 0),
            mk(0, 15, 1, 0, 15, 1, 30, 0, 0),
            mk(0, 15, 1, 0, 15, 1, 45, 0, 0),
            mk(0, 15, 1, 0, 15, 1, 60, 1, 0),
            mk(0, 15, 1, 0, 15, 1, 15, 0, 0),
            mk(2, 7, 1, 1,  5, 1,  5, 0, 0),
            mk(2, 7, 1, 0,  5, 1, 10, 0, 0),
            mk(1, 4, 1, 1,  3, 1,  3, 0, 0),
            mk(1, 4, 1, 0,  3, 1,  6, 0, 0),
            mk(1, 4, 1, 0,  3, 1,  9, 0, 0),
            mk(1, 4, 1, 0,  3, 1, 12, 1, 0),
            mk(12, 4, 0, 0, 8, 0,  0, 0, 0)
        };
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held, new pair refused until out_ready
        apply(mk(5, 1, 0, 0, 4, 0, 0, 0, 0), "bp_first");
        bus.out_ready = 1'b0;
        bus.A = 4'd0;
        bus.B = 4'd15;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_S_held",    32'(bus.S),         32'd4);
            chk("bp_sinal",     32'(bus.sinal),     32'd0);
        end
        bus.out_ready = 1'b1;
        apply(mk(0, 15, 0, 0, 15, 1, 0, 0, 0), "bp_release");
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_S_kept",    32'(bus.S),         32'd15);

        // limpar with no transfer clears the block but not the pending outputs
        apply(mk(1, 2, 1, 0, 1, 1, 1, 0, 0), "lp_pre");
        bus.in_valid = 1'b0;
        bus.limpar   = 1'b1;
        @(posedge clk);
        #1;
        chk("lp_soma_kept", 32'(bus.soma), 32'd1);
        bus.limpar = 1'b0;
        apply(mk(3, 1, 1, 0, 2, 0, 2, 0, 0), "lp_post");

        // Asynchronous reset mid-block with a result pending
        apply(mk(1, 2, 1, 0, 1, 1, 3, 0, 0), "mid_blk");
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("arst_S",          32'(bus.S),          32'd0);
        chk("arst_sinal",      32'(bus.sinal),      32'd0);
        chk("arst_soma",       32'(bus.soma),       32'd0);
        chk("arst_soma_valid", 32'(bus.soma_valid), 32'd0);
        chk("arst_ovf",        32'(bus.ovf),        32'd0);
        #1;
        reset = 1'b0;
        exp_q.delete();
        for (int k = 1; k <= 4; k++) begin
            apply(mk(1, 2, 1, 0, 1, 1, k, (k == 4) ? 1 : 0, 0), $sformatf("post_rst%0d", k));
        end
        bus.in_valid = 1'b0;

        // Overflow on the 5-bit accumulator instance
`ifdef DIFERENCA_ACUM_SAT_EN
        exp_soma5 = '{15, 30, 31, 31, 15};
`else
        exp_soma5 = '{15, 30, 13, 28, 15};
`endif
        exp_ovf5 = '{0, 0, 1, 1, 0};
        exp_sv5  = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            bus5.in_valid = 1'b1;
            bus5.A        = 4'd0;
            bus5.B        = 4'd15;
            bus5.acum     = 1'b1;
            #1;
            chk($sformatf("ovf%0d_accept", i), 32'(bus5.in_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("ovf%0d_out_valid", i),  32'(bus5.out_valid),  32'd1);
            chk($sformatf("ovf%0d_soma", i),       32'(bus5.soma),       32'(exp_soma5[i]));
            chk($sformatf("ovf%0d_ovf", i),        32'(bus5.ovf),        32'(exp_ovf5[i]));
            chk($sformatf("ovf%0d_soma_valid", i), 32'(bus5.soma_valid), 32'(exp_sv5[i]));
        end
        bus5.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/diferenca_acum.md
Name: diferenca_acum

Overview:
Parametrised, registered absolute-difference unit. Each cycle it can accept one (A, B) operand pair and returns |A−B| with a sign flag (1 = A<B) over a valid/ready output buffer. An optional accumulate mode sums |A−B| over fixed blocks of N_SAMPLES pairs (sum of absolute differences), with overflow detection. It sits between operand sources and downstream consumers that may apply backpressure.

Parameters:
WIDTH, 4, operand and difference width in bits (≥2)
ACC_WIDTH, 8, accumulator width in bits (≥ WIDTH)
N_SAMPLES, 4, accumulated pairs per block (≥1); counter width = max(1, clog2(N_SAMPLES))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair present
in_ready  output  1  block can accept a pair this cycle
A  input  WIDTH  unsigned operand A
B  input  WIDTH  unsigned operand B
acum  input  1  pair belongs to an accumulation block; sampled with the transfer
limpar  input  1  synchronous clear of accumulator, counter and ovf
out_valid  output  1  result registers hold an unconsumed result
out_ready  input  1  consumer takes the result
S  output  WIDTH  |A−B|
sinal  output  1  1 = A<B (negative); 0 when A≥B, including A=B
soma  output  ACC_WIDTH  running accumulator value after this transfer
soma_valid  output  1  this result completes an N_SAMPLES block
ovf  output  1  accumulator overflowed in the current block (sticky)

Behaviour:
- Reset (async, while asserted): all outputs 0, FSM in OCIOSO, counter 0, accumulator 0. Takes effect immediately, including mid-block and mid-handshake. Any pending result is discarded.
- FSM has two states: OCIOSO (no pending result) and CHEIO (result held).
- in_ready = (state == OCIOSO) || out_ready. This is combinational and depends on no other input.
- Transfer occurs when in_valid && in_ready at a clock edge. Latency is 1 cycle: S/sinal are visible with out_valid=1 in the following cycle.
- On transfer, the block captures S = |A−B| (WIDTH bits, exact) and sinal = (A<B). The state goes to CHEIO.
- OCIOSO with no transfer: the block stays in OCIOSO with out_valid=0.
- CHEIO with out_ready=1 and no transfer: the state goes to OCIOSO, out_valid becomes 0, and the other outputs keep their last values.
- CHEIO with out_ready=1 and a transfer: the state stays CHEIO and the new result replaces the old one, giving back-to-back throughput of one pair per cycle.
- CHEIO with out_ready=0: every output is held stable and in_ready=0.
- Accumulation applies only on a transfer with acum=1:
  - next = acc + zero-extended S.
  - ovf is set if the true sum exceeds 2^ACC_WIDTH−1.
  - counter increments by 1.
  - If the counter was N_SAMPLES−1: soma_valid=1 with this result, the counter returns to 0, and the internal accumulator and ovf clear before the next transfer. soma and ovf still show the block's final value with this result.
- A transfer with acum=0 leaves the accumulator, counter and ovf unchanged and gives soma_valid=0. soma shows the current accumulator value.
- limpar=1 with no transfer: the accumulator, counter and ovf become 0 at the edge. Pending outputs are not altered.
- limpar=1 together with an acum=1 transfer: the transfer starts a new block (acc = S, counter = 1, ovf = 0).
- soma_valid is meaningful only while out_valid=1 and is held with the result under backpressure.
- N_SAMPLES=1: every acum=1 transfer asserts soma_valid with soma = S.

Optional Feature:
- Macro DIFERENCA_ACUM_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_WIDTH−1 on overflow and stays there for the rest of the block.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH.
- In both builds ovf is set identically and is sticky until the block ends, limpar, or reset.

Test Plan:
1. Defaults, A=3, B=9, acum=0, out_ready=1 → next cycle out_valid=1, S=6, sinal=1, soma_valid=0. Then A=9, B=3 → S=6, sinal=0. Then A=B=7 → S=0, sinal=0.
2. Backpressure: accept A=5, B=1, hold out_ready=0 for 3 cycles while presenting A=0, B=15 → in_ready=0 and S=4 held stable. Raise out_ready → (0,15) is accepted and the next result is S=15, sinal=1.
3. Accumulate: four acum=1 transfers of (0,15) back-to-back → soma = 15, 30, 45, 60, with soma_valid=1 only on the 4th. A fifth transfer gives soma=15, soma_valid=0.
4. Overflow: ACC_WIDTH=5, acum=1 transfers (0,15)×3 → third result has ovf=1. soma=31 with DIFERENCA_ACUM_SAT_EN defined, soma=13 without.
5. limpar: two acum transfers of (2,7) (soma=10), then limpar=1 together with transfer (1,4) → soma=3, and the block completes three transfers later.
6. Reset mid-block: after two acum transfers and with out_valid=1, assert reset asynchronously between edges → all outputs 0 immediately. After release, four acum transfers of (1,2) → soma_valid on the 4th with soma=4.
